// File: rtl/dm_dmi_responder_if.sv
// DMI request/response link between the DTM side (master) and the Debug Module (slave).
// A request is taken on req_valid & req_ready; a response is taken on resp_valid & resp_ready.
interface dm_dmi_responder_if;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_resp;
  logic        resp_valid;
  logic        resp_ready;

  modport master (
    output req_addr, req_op, req_data, req_valid, resp_ready,
    input  req_ready, resp_data, resp_resp, resp_valid
  );

  modport slave (
    input  req_addr, req_op, req_data, req_valid, resp_ready,
    output req_ready, resp_data, resp_resp, resp_valid
  );
endinterface

// File: rtl/dm_dmi_responder.sv
// Debug-Module DMI target: decodes DMI requests into a DM register subset and drives run control.
// Optional macro DM_DMI_BUSY_RESP_EN: accesses blocked by a busy command engine answer DTM_BUSY.
module dm_dmi_responder #(
  parameter int NrData      = 2,
  parameter int ProgBufSize = 8
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  dm_dmi_responder_if.slave                               dmi,
  input  logic                                            hart_halted_i,
  input  logic                                            cmd_busy_i,
  output logic                                            cmd_valid_o,
  output logic [31:0]                                     cmd_o,
  output logic [32*NrData-1:0]                            data_o,
  input  logic [NrData-1:0]                               data_we_i,
  input  logic [32*NrData-1:0]                            data_i,
  output logic [32*(ProgBufSize > 0 ? ProgBufSize : 1)-1:0] progbuf_o,
  output logic                                            haltreq_o,
  output logic                                            resumereq_o,
  output logic                                            ndmreset_o,
  output logic                                            dmactive_o
);

  localparam int PbW = (ProgBufSize > 0) ? ProgBufSize : 1;

  localparam logic [1:0] OP_READ      = 2'd1;
  localparam logic [1:0] OP_WRITE     = 2'd2;
  localparam logic [1:0] OP_RESERVED  = 2'd3;
  localparam logic [1:0] RESP_SUCCESS = 2'd0;
  localparam logic [1:0] RESP_DTM_ERR = 2'd2;
`ifdef DM_DMI_BUSY_RESP_EN
  localparam logic [1:0] RESP_DTM_BUSY = 2'd3;
`endif

  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  typedef enum logic {ST_IDLE, ST_RESPOND} state_e;

  state_e                    state_reg, state_next;
  logic [31:0]               resp_data_reg, resp_data_next;
  logic [1:0]                resp_code_reg, resp_code_next;
  logic [NrData-1:0][31:0]   data_reg, data_next;
  logic [PbW-1:0][31:0]      pb_reg, pb_next;
  logic [31:0]               cmd_reg, cmd_next;
  logic                      cmd_valid_reg, cmd_valid_next;
  logic [2:0]                cmderr_reg, cmderr_next;
  logic                      haltreq_reg, haltreq_next;
  logic                      resumereq_reg, resumereq_next;
  logic                      ndmreset_reg, ndmreset_next;
  logic                      dmactive_reg, dmactive_next;

  logic        req_fire;
  logic        is_rd;
  logic        is_wr;
  logic        hit_data;
  logic        hit_pb;
  logic        blocked;
  logic        wr_en;
  logic [31:0] rdata;

  // Address decode and read mux, evaluated on the request currently presented.
  always_comb begin
    hit_data = 1'b0;
    hit_pb   = 1'b0;
    rdata    = '0;
    for (int i = 0; i < NrData; i++) begin
      if (dmi.req_addr == 7'(4 + i)) begin
        hit_data = 1'b1;
        rdata    = data_reg[i];
      end
    end
    for (int i = 0; i < ProgBufSize; i++) begin
      if (dmi.req_addr == 7'(32 + i)) begin
        hit_pb = 1'b1;
        rdata  = pb_reg[i];
      end
    end
    case (dmi.req_addr)
      ADDR_DMCONTROL:  rdata = {haltreq_reg, 29'b0, ndmreset_reg, dmactive_reg};
      ADDR_DMSTATUS:   rdata = {20'b0, ~hart_halted_i, ~hart_halted_i, hart_halted_i,
                                hart_halted_i, 1'b1, 3'b0, 4'd2};
      ADDR_ABSTRACTCS: rdata = {3'b0, 5'(ProgBufSize), 11'b0, cmd_busy_i, 1'b0,
                                cmderr_reg, 4'b0, 4'(NrData)};
      default:         ;
    endcase
    is_rd    = (dmi.req_op == OP_READ);
    is_wr    = (dmi.req_op == OP_WRITE);
    req_fire = (state_reg == ST_IDLE) && dmi.req_valid;
    // Data words are off limits to the debugger while the engine owns them.
    blocked  = cmd_busy_i && ((hit_data && (is_rd || is_wr)) ||
                              (is_wr && (hit_pb || dmi.req_addr == ADDR_COMMAND)));
    wr_en    = req_fire && is_wr && !blocked && dmactive_reg;
  end

  always_comb begin
    state_next     = state_reg;
    resp_data_next = resp_data_reg;
    resp_code_next = resp_code_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dmi.req_valid) begin
          state_next     = ST_RESPOND;
          resp_data_next = '0;
          resp_code_next = RESP_SUCCESS;
          if (dmi.req_op == OP_RESERVED) begin
            resp_code_next = RESP_DTM_ERR;
          end else if (blocked) begin
`ifdef DM_DMI_BUSY_RESP_EN
            resp_code_next = RESP_DTM_BUSY;
`endif
          end else if (is_rd) begin
            resp_data_next = rdata;
          end
        end
      end
      ST_RESPOND: begin
        if (dmi.resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    data_next      = data_reg;
    pb_next        = pb_reg;
    cmd_next       = cmd_reg;
    cmd_valid_next = 1'b0;
    cmderr_next    = cmderr_reg;
    haltreq_next   = haltreq_reg;
    resumereq_next = 1'b0;
    ndmreset_next  = ndmreset_reg;
    dmactive_next  = dmactive_reg;
    if (!dmactive_reg) begin
      // Inactive DM: everything but dmactive is held at zero.
      data_next     = '0;
      pb_next       = '0;
      cmd_next      = '0;
      cmderr_next   = '0;
      haltreq_next  = 1'b0;
      ndmreset_next = 1'b0;
      if (req_fire && is_wr && dmi.req_addr == ADDR_DMCONTROL) begin
        dmactive_next = dmi.req_data[0];
      end
    end else begin
`ifndef DM_DMI_BUSY_RESP_EN
      if (req_fire && blocked && cmderr_reg == 3'd0) begin
        cmderr_next = 3'd1;
      end
`endif
      if (wr_en) begin
        case (dmi.req_addr)
          ADDR_DMCONTROL: begin
            dmactive_next  = dmi.req_data[0];
            haltreq_next   = dmi.req_data[31] & dmi.req_data[0];
            ndmreset_next  = dmi.req_data[1] & dmi.req_data[0];
            resumereq_next = dmi.req_data[30] & ~dmi.req_data[31] & dmi.req_data[0];
          end
          ADDR_ABSTRACTCS: cmderr_next = cmderr_reg & ~dmi.req_data[10:8];
          ADDR_COMMAND: begin
            if (cmderr_reg == 3'd0) begin
              cmd_next       = dmi.req_data;
              cmd_valid_next = 1'b1;
            end
          end
          default: ;
        endcase
        for (int i = 0; i < NrData; i++) begin
          if (dmi.req_addr == 7'(4 + i)) data_next[i] = dmi.req_data;
        end
        for (int i = 0; i < ProgBufSize; i++) begin
          if (dmi.req_addr == 7'(32 + i)) pb_next[i] = dmi.req_data;
        end
      end
      // Engine write-back comes last so it wins over a same-cycle DMI write.
      for (int i = 0; i < NrData; i++) begin
        if (data_we_i[i]) data_next[i] = data_i[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      resp_data_reg <= '0;
      resp_code_reg <= '0;
      data_reg      <= '0;
      pb_reg        <= '0;
      cmd_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      cmderr_reg    <= '0;
      haltreq_reg   <= 1'b0;
      resumereq_reg <= 1'b0;
      ndmreset_reg  <= 1'b0;
      dmactive_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      resp_data_reg <= resp_data_next;
      resp_code_reg <= resp_code_next;
      data_reg      <= data_next;
      pb_reg        <= pb_next;
      cmd_reg       <= cmd_next;
      cmd_valid_reg <= cmd_valid_next;
      cmderr_reg    <= cmderr_next;
      haltreq_reg   <= haltreq_next;
      resumereq_reg <= resumereq_next;
      ndmreset_reg  <= ndmreset_next;
      dmactive_reg  <= dmactive_next;
    end
  end

  assign dmi.req_ready  = (state_reg == ST_IDLE);
  assign dmi.resp_valid = (state_reg == ST_RESPOND);
  assign dmi.resp_data  = resp_data_reg;
  assign dmi.resp_resp  = resp_code_reg;
  assign cmd_valid_o    = cmd_valid_reg;
  assign cmd_o          = cmd_reg;
  assign data_o         = data_reg;
  assign progbuf_o      = pb_reg;
  assign haltreq_o      = haltreq_reg;
  assign resumereq_o    = resumereq_reg;
  assign ndmreset_o     = ndmreset_reg;
  assign dmactive_o     = dmactive_reg;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Directed plus randomized bench for dm_dmi_responder against a transaction-level register model.
module tb_dm_dmi_responder;
  localparam int NRD = 2;
  localparam int PBS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_dmi_responder_if dmi();

  logic               hart_halted, cmd_busy, cmd_valid;
  logic [31:0]        cmd;
  logic [32*NRD-1:0]  data_o, data_i;
  logic [NRD-1:0]     data_we;
  logic [32*PBS-1:0]  progbuf;
  logic               haltreq, resumereq, ndmreset, dmactive;

  dm_dmi_responder #(.NrData(NRD), .ProgBufSize(PBS)) dut (
    .clk_i(clk), .rst_i(rst), .dmi(dmi),
    .hart_halted_i(hart_halted), .cmd_busy_i(cmd_busy),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd),
    .data_o(data_o), .data_we_i(data_we), .data_i(data_i),
    .progbuf_o(progbuf),
    .haltreq_o(haltreq), .resumereq_o(resumereq),
    .ndmreset_o(ndmreset), .dmactive_o(dmactive)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int cmd_pulses = 0;
  int resume_pulses = 0;

  always @(negedge clk) begin
    if (cmd_valid)  cmd_pulses    <= cmd_pulses + 1;
    if (resumereq)  resume_pulses <= resume_pulses + 1;
  end

  // Reference model state
  logic [31:0] m_data [NRD];
  logic [31:0] m_pb   [PBS];
  logic [31:0] m_cmd;
  logic [2:0]  m_cmderr;
  logic        m_active, m_haltreq, m_ndmreset;
  int          m_cmd_pulses = 0;
  int          m_resume_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NRD; i++) m_data[i] = '0;
    for (int i = 0; i < PBS; i++) m_pb[i] = '0;
    m_cmd = '0; m_cmderr = '0; m_haltreq = 0; m_ndmreset = 0;
  endtask

  task automatic model_access(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd,
                              input logic busy, input logic halted,
                              output logic [1:0] er, output logic [31:0] ed);
    int  idx;
    bit  is_data, is_pb;
    er = 2'd0; ed = 32'd0;
    idx = int'(a);
    is_data = (idx >= 4) && (idx < 4 + NRD);
    is_pb   = (idx >= 32) && (idx < 32 + PBS);
    if (op == 2'd3) begin er = 2'd2; return; end
    if (op == 2'd0) return;
    if (busy && (is_data || (op == 2'd2 && (is_pb || idx == 'h17)))) begin
      if (m_active && m_cmderr == 0) m_cmderr = 3'd1;
      return;
    end
    if (op == 2'd1) begin
      if (is_data) ed = m_data[idx-4];
      else if (is_pb) ed = m_pb[idx-32];
      else if (idx == 'h10) ed = (32'(m_haltreq) << 31) | (32'(m_ndmreset) << 1) | 32'(m_active);
      else if (idx == 'h11) ed = 32'd2 | (32'd1 << 7) | ((halted ? 32'd3 : 32'd0) << 8)
                                 | ((halted ? 32'd0 : 32'd3) << 10);
      else if (idx == 'h16) ed = (32'(PBS) << 24) | (32'(busy) << 12) | (32'(m_cmderr) << 8) | 32'(NRD);
      return;
    end
    if (!m_active) begin
      if (idx == 'h10) m_active = wd[0];
      return;
    end
    if (is_data) m_data[idx-4] = wd;
    else if (is_pb) m_pb[idx-32] = wd;
    else if (idx == 'h10) begin
      if (!wd[0]) begin m_active = 0; model_clear(); end
      else begin
        m_haltreq = wd[31]; m_ndmreset = wd[1];
        if (wd[30] && !wd[31]) m_resume_pulses++;
      end
    end else if (idx == 'h16) m_cmderr = m_cmderr & ~wd[10:8];
    else if (idx == 'h17 && m_cmderr == 0) begin m_cmd = wd; m_cmd_pulses++; end
  endtask

  // One full request/response exchange with handshake timing checks.
  task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd,
                          output logic [1:0] gr, output logic [31:0] gd);
    int cnt;
    @(negedge clk);
    dmi.req_op = op; dmi.req_addr = a; dmi.req_data = wd; dmi.req_valid = 1'b1;
    cnt = 0;
    while (dmi.req_ready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("req_ready_wait", 32'(cnt < 20), 32'd1);
    @(posedge clk); #1;
    dmi.req_valid = 1'b0;
    chk("resp_valid_next_cycle", 32'(dmi.resp_valid), 32'd1);
    chk("req_ready_low_in_respond", 32'(dmi.req_ready), 32'd0);
    gr = dmi.resp_resp; gd = dmi.resp_data;
    dmi.resp_ready = 1'b1;
    @(posedge clk); #1;
    dmi.resp_ready = 1'b0;
    chk("req_ready_back", 32'(dmi.req_ready), 32'd1);
    chk("resp_valid_dropped", 32'(dmi.resp_valid), 32'd0);
  endtask

  task automatic txn(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd,
                     output logic [31:0] gd);
    logic [1:0] gr, er;
    logic [31:0] ed;
    dmi_xfer(op, a, wd, gr, gd);
    model_access(op, a, wd, cmd_busy, hart_halted, er, ed);
    $display("txn op=%0d addr=0x%02h wdata=0x%08h busy=%0d -> resp=%0d rdata=0x%08h (exp %0d/0x%08h)",
             op, a, wd, cmd_busy, gr, gd, er, ed);
    chk($sformatf("resp@%02h", a), 32'(gr), 32'(er));
    chk($sformatf("rdata@%02h", a), gd, ed);
    chk("haltreq_o", 32'(haltreq), 32'(m_haltreq));
    chk("dmactive_o", 32'(dmactive), 32'(m_active));
    chk("cmd_pulses", 32'(cmd_pulses), 32'(m_cmd_pulses));
    chk("resume_pulses", 32'(resume_pulses), 32'(m_resume_pulses));
    chk("cmd_o", cmd, m_cmd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0]  addr_tbl [13];
  logic [31:0] rd, ed, stall_data;
  logic [1:0]  gr, er;
  int          r;
  logic [6:0]  a;
  logic [31:0] wd;
  logic [1:0]  op;

  initial begin
    addr_tbl = '{7'h04, 7'h05, 7'h06, 7'h10, 7'h11, 7'h16, 7'h17,
                 7'h20, 7'h21, 7'h25, 7'h27, 7'h28, 7'h3F};
    rst = 1'b1; hart_halted = 0; cmd_busy = 0; data_we = '0; data_i = '0;
    dmi.req_valid = 0; dmi.req_op = 0; dmi.req_addr = 0; dmi.req_data = 0; dmi.resp_ready = 0;
    m_active = 0; model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(dmi.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(dmi.resp_valid), 32'd0);
    chk("rst_resp_data", dmi.resp_data, 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_dmactive", 32'(dmactive), 32'd0);
    @(negedge clk); rst = 1'b0;

    // dmstatus
    txn(2'd1, 7'h11, 32'd0, rd);
    chk("dmstatus_running", rd, 32'h0000_0C82);
    hart_halted = 1;
    txn(2'd1, 7'h11, 32'd0, rd);
    hart_halted = 0;

    // activate, data0 write/read
    txn(2'd2, 7'h10, 32'd1, rd);
    txn(2'd2, 7'h04, 32'hCAFE_F00D, rd);
    txn(2'd1, 7'h04, 32'd0, rd);
    chk("data0_read", rd, 32'hCAFE_F00D);
    chk("data_o_word0", data_o[31:0], 32'hCAFE_F00D);

    // command launch
    txn(2'd2, 7'h17, 32'h0022_1000, rd);
    chk("cmd_o_launch", cmd, 32'h0022_1000);

    // blocked data write while busy, then W1C of cmderr
    cmd_busy = 1;
    txn(2'd2, 7'h04, 32'h1234_5678, rd);
    cmd_busy = 0;
    txn(2'd1, 7'h16, 32'd0, rd);
    chk("abstractcs_cmderr1", rd, 32'h0800_0102);
    txn(2'd1, 7'h04, 32'd0, rd);
    chk("data0_unchanged", rd, 32'hCAFE_F00D);
    txn(2'd2, 7'h16, 32'h0000_0700, rd);
    txn(2'd1, 7'h16, 32'd0, rd);
    chk("abstractcs_cleared", rd, 32'h0800_0002);

    // progbuf
    txn(2'd2, 7'h23, 32'h0010_0073, rd);
    txn(2'd1, 7'h23, 32'd0, rd);
    chk("progbuf_o_word3", progbuf[127:96], 32'h0010_0073);

    // back-pressure: response held 5 cycles, second request stalls
    @(negedge clk);
    dmi.req_op = 2'd1; dmi.req_addr = 7'h04; dmi.req_valid = 1;
    @(posedge clk); #1;
    model_access(2'd1, 7'h04, 32'd0, cmd_busy, hart_halted, er, ed);
    dmi.req_op = 2'd2; dmi.req_addr = 7'h05; dmi.req_data = 32'h5555_AAAA;
    stall_data = dmi.resp_data;
    chk("stall_first_data", stall_data, ed);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      $display("stall cycle %0d: resp_valid=%0d req_ready=%0d resp_data=0x%08h",
               k, dmi.resp_valid, dmi.req_ready, dmi.resp_data);
      chk("stall_resp_valid", 32'(dmi.resp_valid), 32'd1);
      chk("stall_resp_data", dmi.resp_data, stall_data);
      chk("stall_req_ready", 32'(dmi.req_ready), 32'd0);
    end
    dmi.resp_ready = 1;
    @(posedge clk); #1;
    dmi.resp_ready = 0;
    chk("stall_release_ready", 32'(dmi.req_ready), 32'd1);
    @(posedge clk); #1;
    dmi.req_valid = 0;
    model_access(2'd2, 7'h05, 32'h5555_AAAA, cmd_busy, hart_halted, er, ed);
    chk("second_req_taken", 32'(dmi.resp_valid), 32'd1);
    chk("second_req_resp", 32'(dmi.resp_resp), 32'(er));
    dmi.resp_ready = 1;
    @(posedge clk); #1;
    dmi.resp_ready = 0;
    txn(2'd1, 7'h05, 32'd0, rd);

    // engine write-back beats a same-cycle DMI write
    @(negedge clk);
    chk("collide_idle", 32'(dmi.req_ready), 32'd1);
    dmi.req_op = 2'd2; dmi.req_addr = 7'h05; dmi.req_data = 32'h1111_2222; dmi.req_valid = 1;
    data_we = 2'b10; data_i = {32'hA5A5_5A5A, 32'h0};
    @(posedge clk); #1;
    dmi.req_valid = 0; data_we = '0;
    dmi.resp_ready = 1;
    @(posedge clk); #1;
    dmi.resp_ready = 0;
    m_data[1] = 32'hA5A5_5A5A;
    chk("engine_wins_data_o", data_o[63:32], 32'hA5A5_5A5A);
    txn(2'd1, 7'h05, 32'd0, rd);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      a = addr_tbl[$urandom_range(0, 12)];
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
      wd = $urandom;
      if (a == 7'h10) wd[0] = 1'b1;
      cmd_busy = ($urandom_range(0, 3) == 0);
      hart_halted = 1'($urandom_range(0, 1));
      txn(op, a, wd, rd);
      chk("rand_data_o0", data_o[31:0], m_data[0]);
    end
    cmd_busy = 0;

    // dmactive drop clears and holds state
    txn(2'd2, 7'h10, 32'h8000_0001, rd);
    txn(2'd2, 7'h04, 32'hDEAD_BEEF, rd);
    txn(2'd2, 7'h20, 32'h0BAD_F00D, rd);
    cmd_busy = 1;
    txn(2'd2, 7'h04, 32'h0, rd);
    cmd_busy = 0;
    txn(2'd2, 7'h10, 32'h0, rd);
    chk("inactive_haltreq", 32'(haltreq), 32'd0);
    txn(2'd1, 7'h04, 32'd0, rd);
    chk("inactive_data0", rd, 32'd0);
    txn(2'd1, 7'h20, 32'd0, rd);
    chk("inactive_progbuf0", rd, 32'd0);
    txn(2'd1, 7'h16, 32'd0, rd);
    chk("inactive_abstractcs", rd, 32'h0800_0002);
    txn(2'd2, 7'h04, 32'h7777_7777, rd);
    txn(2'd2, 7'h10, 32'h1, rd);
    txn(2'd1, 7'h04, 32'd0, rd);
    chk("reactivated_data0", rd, 32'd0);

    // reset in the middle of a pending response
    @(negedge clk);
    dmi.req_op = 2'd1; dmi.req_addr = 7'h11; dmi.req_valid = 1;
    @(posedge clk); #1;
    dmi.req_valid = 0;
    chk("midrst_pending", 32'(dmi.resp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(dmi.resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(dmi.req_ready), 32'd1);
    chk("midrst_dmactive", 32'(dmactive), 32'd0);
    chk("midrst_resp_data", dmi.resp_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    m_active = 0; model_clear();
    txn(2'd1, 7'h11, 32'd0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
